// File: rtl/ccgrcg_response_checker.sv
// Exhaustive self-test wrapper for a CCGRCG combinational benchmark: sweeps all input
// vectors, compacts the registered responses into a MISR and compares with a golden value.
module ccgrcg_response_checker #(
    parameter int unsigned      N_IN       = 5,
    parameter int unsigned      N_OUT      = 17,
    parameter logic [N_OUT-1:0] POLY       = 17'h12000,
    parameter logic [N_OUT-1:0] GOLDEN_SIG = 17'h00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  dut_x,
    input  logic [N_OUT-1:0] dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT-1:0] signature
);

    localparam logic [N_IN-1:0] XOne = N_IN'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [N_IN-1:0]  dut_x_q, dut_x_d;
    logic [N_OUT-1:0] f_q, f_d;
    logic             fv_q, fv_d;
    logic [N_OUT-1:0] sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_OUT-1:0] misr_next;

    // Shift left, fold the shifted-out MSB back through the taps, then absorb the capture.
    always_comb begin
        misr_next = {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? POLY : '0) ^ f_q;
    end

    always_comb begin
        state_d = state_q;
        dut_x_d = dut_x_q;
        f_d     = f_q;
        fv_d    = fv_q;
        sig_d   = sig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    dut_x_d = '0;
                    sig_d   = '0;
                    fv_d    = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                // Response to the vector driven last cycle has now settled.
                f_d  = dut_f;
                fv_d = 1'b1;
                if (fv_q) begin
                    sig_d = misr_next;
                end
                if (&dut_x_q) begin
                    state_d = StDrain;
                end else begin
                    dut_x_d = dut_x_q + XOne;
                end
            end
            StDrain: begin
                if (fv_q) begin
                    sig_d = misr_next;
                end
                state_d = StIdle;
                fv_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (sig_d == GOLDEN_SIG);
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dut_x_q <= '0;
            f_q     <= '0;
            fv_q    <= 1'b0;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dut_x_q <= dut_x_d;
            f_q     <= f_d;
            fv_q    <= fv_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign dut_x     = dut_x_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_ccgrcg_response_checker.sv
// Randomized self-checking bench for ccgrcg_response_checker: three instances cover the
// 5-input sweep, the 1-input boundary case and a golden-signature run over a stand-in netlist.
module tb_ccgrcg_response_checker;

    localparam logic [16:0] Poly = 17'h12000;

    function automatic logic [16:0] misr_step(input logic [16:0] s, input logic [16:0] r);
        logic [16:0] sh;
        sh = s << 1;
        if (s[16]) sh = sh ^ Poly;
        return sh ^ r;
    endfunction

    // Stand-in for a benchmark netlist: an arbitrary fixed 5-in/17-out function.
    function automatic logic [16:0] netf(input logic [4:0] x);
        logic [31:0] h;
        h = 32'(x) * 32'h9E3779B1 + 32'h7F4A7C15;
        return h[27:11];
    endfunction

    function automatic logic [16:0] net_golden();
        logic [16:0] s;
        s = '0;
        for (int k = 0; k < 32; k++) s = misr_step(s, netf(5'(k)));
        return s;
    endfunction

    localparam logic [16:0] NetGolden = net_golden();

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic [4:0]  x_a, x_c;
    logic [0:0]  x_b;
    logic [16:0] f_a, f_b, f_c;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
    logic [16:0] sig_a, sig_b, sig_c;

    int          mode_a;
    logic [16:0] lut_a [32];
    logic [16:0] const_b;
    logic        fault_en;
    logic [4:0]  fault_vec;
    logic [16:0] fault_mask;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        f_a = '0;
        if (mode_a == 1) f_a = lut_a[x_a];
        else if (mode_a == 2) f_a = netf(x_a);
        f_b = const_b;
        f_c = netf(x_c) ^ ((fault_en && x_c == fault_vec) ? fault_mask : 17'h0);
    end

    ccgrcg_response_checker #(.N_IN(5), .N_OUT(17), .POLY(Poly), .GOLDEN_SIG(17'h00000)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_x(x_a), .dut_f(f_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
    );

    ccgrcg_response_checker #(.N_IN(1), .N_OUT(17), .POLY(Poly), .GOLDEN_SIG(17'h00003)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_x(x_b), .dut_f(f_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
    );

    ccgrcg_response_checker #(.N_IN(5), .N_OUT(17), .POLY(Poly), .GOLDEN_SIG(NetGolden)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .dut_x(x_c), .dut_f(f_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c)
    );

    function automatic logic [16:0] resp_a(input int j);
        if (mode_a == 1) return lut_a[j];
        if (mode_a == 2) return netf(5'(j));
        return 17'h0;
    endfunction

    // Call at a negedge; start is asserted here so it is taken at the next edge (E0).
    task automatic run_a(input int again_at, input string tag);
        logic [16:0] s_exp;
        logic [4:0]  x_exp;
        s_exp = '0;
        start_a = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 32; k++) begin
            start_a = 1'b0;
            if (k >= 2) s_exp = misr_step(s_exp, resp_a(k - 2));
            x_exp = (k > 31) ? 5'd31 : 5'(k);
            n_checks++;
            if (x_a !== x_exp || busy_a !== 1'b1 || done_a !== 1'b0 || sig_a !== s_exp) begin
                n_fail++;
                $display("FAIL %s sweep E%0d: got dut_x=%0d busy=%b done=%b sig=%h, required dut_x=%0d busy=1 done=0 sig=%h",
                         tag, k, x_a, busy_a, done_a, sig_a, x_exp, s_exp);
            end
            if (k + 1 == again_at) start_a = 1'b1;
            @(negedge clk);
        end
        start_a = 1'b0;
        s_exp = misr_step(s_exp, resp_a(31));
        n_checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || sig_a !== s_exp || pass_a !== (s_exp == 17'h0)) begin
            n_fail++;
            $display("FAIL %s done E33: got done=%b busy=%b sig=%h pass=%b, required done=1 busy=0 sig=%h pass=%b",
                     tag, done_a, busy_a, sig_a, pass_a, s_exp, s_exp == 17'h0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({x_a, busy_a, done_a, pass_a, sig_a} !== '0 || {x_b, busy_b, done_b, pass_b, sig_b} !== '0 ||
            {x_c, busy_c, done_c, pass_c, sig_c} !== '0) begin
            n_fail++;
            $display("FAIL reset: got a=%h/%b%b%b/%h b=%h/%b%b%b/%h c=%h/%b%b%b/%h, required all zero",
                     x_a, busy_a, done_a, pass_a, sig_a, x_b, busy_b, done_b, pass_b, sig_b,
                     x_c, busy_c, done_c, pass_c, sig_c);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_response();
        logic [16:0] held;
        mode_a = 0;
        run_a(0, "zero");
        held = sig_a;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done_a !== 1'b0 || pass_a !== 1'b1 || sig_a !== held || busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_hold: got done=%b pass=%b sig=%h busy=%b, required done=0 pass=1 sig=%h busy=0",
                         done_a, pass_a, sig_a, busy_a, held);
            end
        end
    endtask

    task automatic test_random_lut();
        for (int r = 0; r < 2; r++) begin
            foreach (lut_a[i]) lut_a[i] = 17'($urandom);
            mode_a = 1;
            @(negedge clk);
            run_a(0, "random_lut");
        end
    endtask

    task automatic test_start_while_busy();
        mode_a = 1;
        @(negedge clk);
        run_a(5, "start_busy");
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_after: got busy=%b done=%b, required busy=0 done=0", busy_a, done_a);
        end
    endtask

    task automatic test_back_to_back();
        mode_a = 0;
        @(negedge clk);
        run_a(0, "b2b_first");
        mode_a = 2;
        run_a(0, "b2b_second");
    endtask

    task automatic test_mid_reset();
        logic saw;
        mode_a = 0;
        @(negedge clk);
        run_a(0, "pre_reset");
        mode_a = 2;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (x_a !== 5'd0 || busy_a !== 1'b0 || sig_a !== 17'h0 || pass_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got dut_x=%0d busy=%b sig=%h pass=%b done=%b, required all zero",
                     x_a, busy_a, sig_a, pass_a, done_a);
        end
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) saw = 1'b1;
        end
        n_checks++;
        if (saw) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got done/busy activity=1, required 0");
        end
        run_a(0, "after_reset");
    endtask

    task automatic test_small(input logic [16:0] c);
        logic [16:0] s2, s3;
        s2 = misr_step(17'h0, c);
        s3 = misr_step(s2, c);
        const_b = c;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        n_checks++;
        if (x_b !== 1'b1 || sig_b !== 17'h0 || busy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL small E1 c=%h: got dut_x=%b sig=%h busy=%b, required dut_x=1 sig=0 busy=1",
                     c, x_b, sig_b, busy_b);
        end
        @(negedge clk);
        n_checks++;
        if (sig_b !== s2 || busy_b !== 1'b1 || done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL small E2 c=%h: got sig=%h busy=%b done=%b, required sig=%h busy=1 done=0",
                     c, sig_b, busy_b, done_b, s2);
        end
        @(negedge clk);
        n_checks++;
        if (sig_b !== s3 || done_b !== 1'b1 || busy_b !== 1'b0 || pass_b !== (s3 == 17'h3)) begin
            n_fail++;
            $display("FAIL small E3 c=%h: got sig=%h done=%b busy=%b pass=%b, required sig=%h done=1 busy=0 pass=%b",
                     c, sig_b, done_b, busy_b, pass_b, s3, s3 == 17'h3);
        end
    endtask

    task automatic test_real_netlist(input logic en, input logic [4:0] vec, input logic [16:0] mask);
        logic [16:0] s_exp;
        int          k;
        fault_en = en; fault_vec = vec; fault_mask = mask;
        s_exp = '0;
        for (int j = 0; j < 32; j++)
            s_exp = misr_step(s_exp, netf(5'(j)) ^ ((en && 5'(j) == vec) ? mask : 17'h0));
        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        k = 0;
        while (done_c !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != 33 || sig_c !== s_exp || pass_c !== (s_exp == NetGolden)) begin
            n_fail++;
            $display("FAIL netlist fault=%b vec=%0d: got done at E%0d sig=%h pass=%b, required E33 sig=%h pass=%b",
                     en, vec, k, sig_c, pass_c, s_exp, s_exp == NetGolden);
        end
    endtask

    initial begin
        mode_a = 0;
        const_b = '0;
        fault_en = 1'b0; fault_vec = '0; fault_mask = '0;
        foreach (lut_a[i]) lut_a[i] = '0;
        test_reset();
        test_zero_response();
        test_random_lut();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        test_small(17'h00001);
        test_small(17'h10000);
        test_small(17'($urandom));
        test_real_netlist(1'b0, 5'd0, 17'h0);
        test_real_netlist(1'b1, 5'd31, 17'h00001);
        test_real_netlist(1'b1, 5'($urandom_range(31)), 17'(1) << $urandom_range(16));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
